// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - PWM channel bank with shadowed TOP/DUTY and a shared prescaler; define PWM_BANK_POLARITY_EN to add the POL register at 0x04
module pwm_bank #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [ADDR_W-1:0] ADDR_EN    = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] ADDR_MODE  = ADDR_W'(8'h01);
    localparam logic [ADDR_W-1:0] ADDR_PRESC = ADDR_W'(8'h02);
    localparam logic [ADDR_W-1:0] ADDR_TOP   = ADDR_W'(8'h03);
`ifdef PWM_BANK_POLARITY_EN
    localparam logic [ADDR_W-1:0] ADDR_POL   = ADDR_W'(8'h04);
`endif

    logic [CNT_W-1:0]  en_q, mode_q, presc_q, top_q;
    logic [CNT_W-1:0]  duty_q   [NUM_CH];
    logic [CNT_W-1:0]  duty_s_q [NUM_CH];
    logic [CNT_W-1:0]  top_s_q, pre_q, cnt_q;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              period_tick_q;
    logic [CNT_W-1:0]  ch_mask;
    logic              tick, wrap;
`ifdef PWM_BANK_POLARITY_EN
    logic [CNT_W-1:0]  pol_q;
`endif

    always_comb begin
        ch_mask = '0;
        for (int i = 0; i < NUM_CH; i++) ch_mask[i] = 1'b1;
    end

    // >= keeps pre in range if PRESC is lowered below the running count
    assign tick = ena && (pre_q >= presc_q);
    assign wrap = tick && (cnt_q == top_s_q);

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < NUM_CH; i++)
            pwm_d[i] = en_q[i] & (mode_q[i] ? (cnt_q < duty_s_q[i]) : 1'b1);
`ifdef PWM_BANK_POLARITY_EN
        pwm_d = pwm_d ^ pol_q[NUM_CH-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q          <= '0;
            mode_q        <= '0;
            presc_q       <= '0;
            top_q         <= '0;
            top_s_q       <= '0;
            pre_q         <= '0;
            cnt_q         <= '0;
            pwm_q         <= '0;
            period_tick_q <= 1'b0;
`ifdef PWM_BANK_POLARITY_EN
            pol_q         <= '0;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i]   <= '0;
                duty_s_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    ADDR_EN:    en_q    <= wr_data & ch_mask;
                    ADDR_MODE:  mode_q  <= wr_data & ch_mask;
                    ADDR_PRESC: presc_q <= wr_data;
                    ADDR_TOP:   top_q   <= wr_data;
`ifdef PWM_BANK_POLARITY_EN
                    ADDR_POL:   pol_q   <= wr_data & ch_mask;
`endif
                    default: ;
                endcase
                for (int i = 0; i < NUM_CH; i++)
                    if (wr_addr == ADDR_W'(16 + i)) duty_q[i] <= wr_data;
            end

            if (tick)
                pre_q <= '0;
            else if (ena)
                pre_q <= pre_q + 1'b1;

            // shadows sample the register values from before any same-cycle write
            if (wrap) begin
                cnt_q   <= '0;
                top_s_q <= top_q;
                for (int i = 0; i < NUM_CH; i++) duty_s_q[i] <= duty_q[i];
            end else if (tick) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (ena) pwm_q <= pwm_d;
            period_tick_q <= wrap;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_EN:    rd_data = en_q;
            ADDR_MODE:  rd_data = mode_q;
            ADDR_PRESC: rd_data = presc_q;
            ADDR_TOP:   rd_data = top_q;
`ifdef PWM_BANK_POLARITY_EN
            ADDR_POL:   rd_data = pol_q;
`endif
            default:    rd_data = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++)
            if (rd_addr == ADDR_W'(16 + i)) rd_data = duty_q[i];
    end

    assign pwm_out     = pwm_q;
    assign period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - directed testbench for pwm_bank
module tb_pwm_bank;
    logic       clk = 1'b0;
    logic       rst, ena, wr_en;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [3:0] pwm_out;
    logic       period_tick;
    int         total = 0;
    int         bad = 0;
    int         len;
    logic [63:0] pat;

    always #5 clk = ~clk;

    pwm_bank #(.NUM_CH(4), .CNT_W(8), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .pwm_out(pwm_out), .period_tick(period_tick)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_addr = a; wr_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] e);
        rd_addr = a;
        #1;
        chk(tag, rd_data, e);
    endtask

    // Samples pwm_out[0] from the current negedge until the next period_tick.
    // Optionally writes (a,d) at sample index wr_at and drops ena for 5 cycles from off_at.
    task automatic measure(input int wr_at, input logic [7:0] a, input logic [7:0] d,
                           input int off_at, output int n, output logic [63:0] p);
        bit done = 1'b0;
        p = '0;
        p[0] = pwm_out[0];
        n = 1;
        for (int s = 0; s < 200 && !done; s++) begin
            wr_en   = ((n - 1) == wr_at);
            wr_addr = a;
            wr_data = d;
            ena     = !(((n - 1) >= off_at) && ((n - 1) < off_at + 5));
            @(negedge clk);
            wr_en = 1'b0;
            ena   = 1'b1;
            if (period_tick) done = 1'b1;
            else begin
                if (n < 64) p[n] = pwm_out[0];
                n++;
            end
        end
        if (!done) chk("measure_timeout", 64'(done), 64'd1);
    endtask

    task automatic settle(input logic [7:0] a, input logic [7:0] d);
        int n;
        logic [63:0] p;
        measure(0, a, d, -100, n, p);
        measure(-1, 8'h00, 8'h00, -100, n, p);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        @(negedge clk); @(negedge clk);
        chk("reset_pwm", 64'(pwm_out), 64'h0);
        chk("reset_tick", 64'(period_tick), 64'h0);
        rd("reset_rd_en", 8'h00, 8'h00);
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("tick_every_cycle_after_reset", 64'(period_tick), 64'h1);

        wr(8'h00, 8'hFF); rd("en_upper_bits_masked", 8'h00, 8'h0F);
        wr(8'h01, 8'hFF); rd("mode_upper_bits_masked", 8'h01, 8'h0F);
        wr(8'h14, 8'h55); rd("unmapped_0x14", 8'h14, 8'h00);

        wr(8'h00, 8'h01); wr(8'h01, 8'h01); wr(8'h02, 8'h00);
        wr(8'h10, 8'h03); wr(8'h03, 8'h09);
        rd("top_readback", 8'h03, 8'h09);
        rd("duty0_readback", 8'h10, 8'h03);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
        chk("basic_period_len", 64'(len), 64'd10);
        chk("basic_pattern", pat, 64'h00E);

        measure(4, 8'h10, 8'h07, -100, len, pat);
        chk("mid_write_current_period", pat, 64'h00E);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
        chk("mid_write_next_period", pat, 64'h0FE);

        measure(9, 8'h10, 8'h02, -100, len, pat);
        chk("wrap_write_period_a", pat, 64'h0FE);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
        chk("wrap_write_keeps_old", pat, 64'h0FE);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
        chk("wrap_write_then_new", pat, 64'h006);

        settle(8'h10, 8'h00);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
        chk("duty0_const_low", pat, 64'h000);
        settle(8'h10, 8'h0A);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
        chk("duty_gt_top_const_high", pat, 64'h3FF);
        settle(8'h01, 8'h00);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
        chk("static_mode_high", pat, 64'h3FF);
        settle(8'h00, 8'h00);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
        chk("disabled_low", pat, 64'h000);

        wr(8'h00, 8'h01); wr(8'h01, 8'h01); wr(8'h10, 8'h03); wr(8'h02, 8'h03);
        settle(8'h03, 8'h04);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
        chk("presc_period_len", 64'(len), 64'd20);
        chk("presc_pattern", pat, 64'h1FFE);
        measure(-1, 8'h00, 8'h00, 6, len, pat);
        chk("ena_drop_period_len", 64'(len), 64'd25);

        wr(8'h02, 8'h00); wr(8'h03, 8'h09);
        settle(8'h04, 8'h01);
        measure(-1, 8'h00, 8'h00, -100, len, pat);
`ifdef PWM_BANK_POLARITY_EN
        chk("pol_inverted_pattern", pat, 64'h3F1);
        rd("pol_readback", 8'h04, 8'h01);
`else
        chk("addr4_no_effect_pattern", pat, 64'h00E);
        rd("addr4_readback_zero", 8'h04, 8'h00);
`endif

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_pwm", 64'(pwm_out), 64'h0);
        chk("async_reset_tick", 64'(period_tick), 64'h0);
        rd("async_reset_en", 8'h00, 8'h00);
        rd("async_reset_top", 8'h03, 8'h00);
        rd("async_reset_duty0", 8'h10, 8'h00);
        rd("async_reset_addr4", 8'h04, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of PWM channels (1..CNT_W).
REQ-002 SHALL have parameter CNT_W, default 8, width of counter, period, duty, prescaler and write data.
REQ-003 SHALL have parameter ADDR_W, default 8, register address width (>=5).
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- ena  in  1  count enable
- wr_en  in  1  register write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  CNT_W  write data
- rd_addr  in  ADDR_W  readback address
- rd_data  out  CNT_W  combinational readback of active register
- pwm_out  out  NUM_CH  registered channel outputs
- period_tick  out  1  one-cycle pulse at period wrap

Function
REQ-006 Register map SHALL be:
- 0x00 EN: bit i enables channel i.
- 0x01 MODE: bit i=1 selects PWM; bit i=0 selects static high.
- 0x02 PRESC.
- 0x03 TOP.
- 0x10+i DUTY[i].
- Bits above NUM_CH in EN/MODE SHALL be written, stored and read back as 0.
REQ-007 A write SHALL take effect at the clock edge where wr_en=1. Writes to unmapped addresses SHALL be ignored, and reads of unmapped addresses SHALL return 0.
REQ-008 Prescaler pre SHALL count 0..PRESC while ena=1. tick SHALL be asserted when pre==PRESC and ena=1, and pre SHALL wrap to 0 on tick.
REQ-009 Counter cnt SHALL increment on tick and wrap to 0 on a tick with cnt==top_s (wrap event). Period SHALL be (top_s+1)*(PRESC+1) cycles.
REQ-010 Shadow registers top_s and duty_s[i] SHALL load from TOP/DUTY[i] only on a wrap event.
REQ-011 If a write and a wrap event occur in the same cycle, the shadow SHALL capture the pre-write value.
REQ-012 pwm_out[i] SHALL be registered, with 1-cycle latency from cnt, equal to EN[i] & (MODE[i] ? (cnt < duty_s[i]) : 1).
- duty_s=0 gives constant low.
- duty_s>top_s gives constant high.
REQ-013 period_tick SHALL be high for exactly the cycle after each wrap event.
REQ-014 With ena=0, pre, cnt, shadows and pwm_out SHALL hold, period_tick SHALL be 0, and register writes SHALL still be accepted.
REQ-015 Arithmetic SHALL be unsigned CNT_W-bit. cnt SHALL never exceed top_s. If TOP is lowered below the current cnt, the change SHALL take effect only at the next wrap (shadowed).

Reset
REQ-016 On rst=1, all registers, shadows, pre, cnt, pwm_out and period_tick SHALL clear to 0 immediately, independent of clk.
REQ-017 After reset release, top_s=0 and PRESC=0, so a wrap event SHALL occur every cycle and written values SHALL reach the shadows one cycle after the write.
REQ-018 Asserting rst mid-period SHALL abort the period with no period_tick.

Configuration
REQ-019 Macro PWM_BANK_POLARITY_EN, when defined, SHALL add register 0x04 POL. The final output SHALL be inverted per bit (pwm_out[i] ^= POL[i]), including disabled channels. POL SHALL reset to 0.
REQ-020 Without PWM_BANK_POLARITY_EN, address 0x04 SHALL be unmapped and no inversion logic SHALL exist.

Verification
REQ-021 Reset: rst pulse asynchronous mid-cycle -> pwm_out=0, period_tick=0, all readbacks 0.
REQ-022 Basic PWM: EN=0x01, MODE=0x01, PRESC=0, TOP=9, DUTY[0]=3 -> pwm_out[0] high 3 of every 10 cycles, and period_tick every 10 cycles.
REQ-023 Shadowing: mid-period write DUTY[0]=7 -> current period keeps 3-high; next period 7-high. A write coincident with wrap -> old value used for that period.
REQ-024 Boundaries: DUTY=0 -> constant 0. DUTY=10 with TOP=9 -> constant 1. MODE bit 0 with EN=1 -> constant 1. EN=0 -> 0.
REQ-025 Prescaler/ena: PRESC=3, TOP=4 -> period_tick every 20 cycles. Dropping ena for 5 cycles -> next tick 5 cycles later.
REQ-026 With PWM_BANK_POLARITY_EN, POL=0x01 -> pwm_out[0] low 3 of 10 cycles. Without the macro, a write to 0x04 -> no effect and readback 0.
